// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle 32-bit MIPS core: one FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// around a single shared ALU, with a req/ready data-memory handshake and an external regfile.
module mips_multicycle_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic [4:0]  register_a1,
   output logic [4:0]  register_a2,
   output logic [4:0]  register_a3,
   output logic        register_we3,
   output logic [31:0] register_wd3,
   input  logic [31:0] register_rd1,
   input  logic [31:0] register_rd2,
   output logic        retire,
   output logic        illegal
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;

   state_t      state, state_next;
   logic [31:0] pc, pc_next, ir, a_reg, b_reg, alu_out, mdr;
   logic [31:0] sign_imm, pc_plus, branch_target, jump_target, alu_b, alu_result;
   logic [5:0]  opcode, funct;
   logic        r_legal, is_nop;

   assign opcode        = ir[31:26];
   assign funct         = ir[5:0];
   assign sign_imm      = {{16{ir[15]}}, ir[15:0]};
   assign pc_plus       = pc + PC_STEP;
   assign branch_target = pc_plus + sign_imm * PC_STEP;
   assign jump_target   = {6'b0, ir[25:0]} * PC_STEP;
   assign is_nop        = (ir == 32'h0);
   assign r_legal       = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                          (funct == F_OR)  || (funct == F_SLT);

   assign imem_addr    = pc;
   assign register_a1  = ir[25:21];
   assign register_a2  = ir[20:16];
   assign register_a3  = (opcode == OP_R) ? ir[15:11] : ir[20:16];
   assign register_wd3 = (opcode == OP_LW) ? mdr : alu_out;
   assign dmem_addr    = alu_out;
   assign dmem_wdata   = b_reg;

   // Shared ALU: R-type uses funct, every other user wants A + sign-extended immediate.
   always_comb begin
      alu_b      = (opcode == OP_R) ? b_reg : sign_imm;
      alu_result = a_reg + alu_b;
      if (opcode == OP_R) begin
         case (funct)
            F_SUB:   alu_result = a_reg - b_reg;
            F_AND:   alu_result = a_reg & b_reg;
            F_OR:    alu_result = a_reg | b_reg;
            F_SLT:   alu_result = {31'b0, $signed(a_reg) < $signed(b_reg)};
            default: alu_result = a_reg + b_reg;
         endcase
      end
   end

   always_comb begin
      state_next   = state;
      pc_next      = pc;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      register_we3 = 1'b0;
      retire       = 1'b0;
      illegal      = 1'b0;
      case (state)
         FETCH: state_next = DECODE;
         DECODE: begin
            case (opcode)
               OP_R: begin
                  if (is_nop) begin
                     retire     = 1'b1;
                     pc_next    = pc_plus;
                     state_next = FETCH;
                  end else if (r_legal) begin
                     state_next = EXEC;
                  end else begin
                     illegal    = 1'b1;
                     pc_next    = pc_plus;
                     state_next = FETCH;
                  end
               end
               OP_LW, OP_SW, OP_ADDI, OP_BEQ: state_next = EXEC;
               OP_J: begin
                  retire     = 1'b1;
                  pc_next    = jump_target;
                  state_next = FETCH;
               end
               default: begin
                  illegal    = 1'b1;
                  pc_next    = pc_plus;
                  state_next = FETCH;
               end
            endcase
         end
         EXEC: begin
            if (opcode == OP_BEQ) begin
               retire     = 1'b1;
               pc_next    = (a_reg == b_reg) ? alu_out : pc_plus;
               state_next = FETCH;
            end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               state_next = MEM;
            end else begin
               state_next = WB;
            end
         end
         // Request stays up with stable address/data until the memory accepts it.
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode == OP_SW);
            if (dmem_ready) begin
               if (opcode == OP_SW) begin
                  retire     = 1'b1;
                  pc_next    = pc_plus;
                  state_next = FETCH;
               end else begin
                  state_next = WB;
               end
            end
         end
         WB: begin
            register_we3 = 1'b1;
            retire       = 1'b1;
            pc_next      = pc_plus;
            state_next   = FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   // The branch target is precomputed in DECODE so EXEC only has to choose.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir      <= 32'h0;
         a_reg   <= 32'h0;
         b_reg   <= 32'h0;
         alu_out <= 32'h0;
         mdr     <= 32'h0;
      end else begin
         case (state)
            FETCH: ir <= imem_rdata;
            DECODE: begin
               a_reg   <= register_rd1;
               b_reg   <= register_rd2;
               alu_out <= branch_target;
            end
            EXEC: if (opcode != OP_BEQ) alu_out <= alu_result;
            MEM:  if (dmem_ready && (opcode == OP_LW)) mdr <= dmem_rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Bench for mips_multicycle_cpu: directed vector table, random instruction stream against an
// instruction-level model, mid-access reset, and a PC_STEP=4 instance for j/illegal.
module tb_mips_multicycle_cpu;

   typedef struct {
      int          lat;
      logic        ill;
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        mem;
      logic        mem_we;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] next_pc;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      int          waits;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, dmem_req, dmem_we, dmem_ready, register_we3, retire, illegal;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0] register_wd3, register_rd1, register_rd2;
   logic [4:0]  register_a1, register_a2, register_a3;

   logic        reset2, dmem_req2, dmem_we2, dmem_ready2, register_we3_2, retire2, illegal2;
   logic [31:0] imem_addr2, imem_rdata2, dmem_addr2, dmem_wdata2, dmem_rdata2;
   logic [31:0] register_wd3_2, register_rd1_2, register_rd2_2;
   logic [4:0]  register_a1_2, register_a2_2, register_a3_2;

   logic [31:0] rf   [32] = '{default: '0};
   logic [31:0] dmem [64] = '{default: '0};

   logic [31:0] mrf  [32];
   logic [31:0] mmem [64];
   logic [31:0] mpc;

   int checks = 0;
   int errors = 0;

   mips_multicycle_cpu #(.RESET_PC(32'h40), .PC_STEP(32'd1)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .register_a1(register_a1), .register_a2(register_a2), .register_a3(register_a3),
      .register_we3(register_we3), .register_wd3(register_wd3),
      .register_rd1(register_rd1), .register_rd2(register_rd2),
      .retire(retire), .illegal(illegal)
   );

   mips_multicycle_cpu #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut2 (
      .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
      .dmem_rdata(dmem_rdata2), .dmem_ready(dmem_ready2),
      .register_a1(register_a1_2), .register_a2(register_a2_2), .register_a3(register_a3_2),
      .register_we3(register_we3_2), .register_wd3(register_wd3_2),
      .register_rd1(register_rd1_2), .register_rd2(register_rd2_2),
      .retire(retire2), .illegal(illegal2)
   );

   assign register_rd1   = (register_a1 == 5'd0) ? 32'd0 : rf[register_a1];
   assign register_rd2   = (register_a2 == 5'd0) ? 32'd0 : rf[register_a2];
   assign dmem_rdata     = dmem[dmem_addr[5:0]];
   assign register_rd1_2 = 32'd0;
   assign register_rd2_2 = 32'd0;
   assign dmem_rdata2    = 32'd0;
   assign dmem_ready2    = 1'b1;

   always @(posedge clk) begin
      if (register_we3 && (register_a3 != 5'd0)) rf[register_a3] <= register_wd3;
      if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr[5:0]] <= dmem_wdata;
   end

   task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input int waits, input int lat,
                               input logic ill, input logic we, input logic [4:0] a3,
                               input logic [31:0] wd, input logic mem, input logic mem_we,
                               input logic [31:0] maddr, input logic [31:0] mwdata,
                               input logic [31:0] next_pc);
      vec_t v;
      v.instr    = instr;   v.waits    = waits;
      v.e.lat    = lat;     v.e.ill    = ill;     v.e.we     = we;
      v.e.a3     = a3;      v.e.wd     = wd;      v.e.mem    = mem;
      v.e.mem_we = mem_we;  v.e.maddr  = maddr;   v.e.mwdata = mwdata;
      v.e.next_pc = next_pc;
      return v;
   endfunction

   // Instruction-level model: architectural effect plus the documented cycle count.
   task automatic modelStep(input logic [31:0] instr, input int waits, output exp_t e);
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, simm, res;
      logic        valid;
      op = instr[31:26]; fn = instr[5:0];
      rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
      a = mrf[rs]; b = mrf[rt];
      simm = {{16{instr[15]}}, instr[15:0]};
      res = 32'd0; valid = 1'b1;
      e.lat = 2; e.ill = 1'b0; e.we = 1'b0; e.a3 = 5'd0; e.wd = 32'd0;
      e.mem = 1'b0; e.mem_we = 1'b0; e.maddr = 32'd0; e.mwdata = 32'd0;
      e.next_pc = mpc + 32'd1;
      case (op)
         6'h00: begin
            if (instr != 32'd0) begin
               case (fn)
                  6'h20:   res = a + b;
                  6'h22:   res = a - b;
                  6'h24:   res = a & b;
                  6'h25:   res = a | b;
                  6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  default: valid = 1'b0;
               endcase
               if (valid) begin
                  e.lat = 4; e.we = 1'b1; e.a3 = rd; e.wd = res;
               end else begin
                  e.ill = 1'b1;
               end
            end
         end
         6'h08: begin e.lat = 4; e.we = 1'b1; e.a3 = rt; e.wd = a + simm; end
         6'h23: begin
            e.lat = 5 + waits; e.mem = 1'b1; e.maddr = a + simm;
            e.we = 1'b1; e.a3 = rt; e.wd = mmem[e.maddr[5:0]];
         end
         6'h2B: begin
            e.lat = 4 + waits; e.mem = 1'b1; e.mem_we = 1'b1;
            e.maddr = a + simm; e.mwdata = b;
            mmem[e.maddr[5:0]] = b;
         end
         6'h04: begin
            e.lat = 3;
            if (a == b) e.next_pc = mpc + 32'd1 + simm;
         end
         6'h02: e.next_pc = {6'b0, instr[25:0]};
         default: e.ill = 1'b1;
      endcase
      if (e.we && (e.a3 != 5'd0)) mrf[e.a3] = e.wd;
      mpc = e.next_pc;
   endtask

   function automatic logic [31:0] randInstr();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [31:0] r;
      int          kind, o;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      o = int'($urandom_range(0, 15)) - 8;
      kind = int'($urandom_range(0, 12));
      case (kind)
         0:  r = {6'h00, rs, rt, rd, 5'h0, 6'h20};
         1:  r = {6'h00, rs, rt, rd, 5'h0, 6'h22};
         2:  r = {6'h00, rs, rt, rd, 5'h0, 6'h24};
         3:  r = {6'h00, rs, rt, rd, 5'h0, 6'h25};
         4:  r = {6'h00, rs, rt, rd, 5'h0, 6'h2A};
         5:  r = {6'h08, rs, rt, imm};
         6:  r = {6'h23, rs, rt, imm};
         7:  r = {6'h2B, rs, rt, imm};
         8:  r = {6'h04, rs, (($urandom_range(0, 1) == 1) ? rs : rt), o[15:0]};
         9:  r = {6'h02, 26'($urandom)};
         10: r = 32'h0;
         11: r = {6'h3F, rs, rt, imm};
         default: r = {6'h00, rs, rt, rd, 5'h0, 6'h21};
      endcase
      return r;
   endfunction

   // Entered at the falling edge of the FETCH cycle; leaves at the falling edge of the next FETCH.
   task automatic applyStimulus(input logic [31:0] instr, input int waits, input exp_t e);
      int   k;
      logic done, bus_bad, early_we, exp_req;
      done = 1'b0; bus_bad = 1'b0; early_we = 1'b0; k = 0;
      imem_rdata = instr;
      while (!done && (k < 40)) begin
         k++;
         if (k > 1) begin
            @(negedge clk);
            imem_rdata = $urandom;
         end
         dmem_ready = e.mem ? (k >= 4 + waits) : 1'($urandom_range(0, 1));
         #1;
         exp_req = e.mem && (k >= 4) && (k <= 4 + waits);
         if (dmem_req !== exp_req) bus_bad = 1'b1;
         else if (exp_req && ((dmem_we !== e.mem_we) || (dmem_addr !== e.maddr) ||
                              (e.mem_we && (dmem_wdata !== e.mwdata)))) bus_bad = 1'b1;
         if (retire || illegal) done = 1'b1;
         else if (register_we3) early_we = 1'b1;
      end
      checkWord("latency", done ? k : 0, e.lat);
      checkBit("retire", retire, !e.ill);
      checkBit("illegal", illegal, e.ill);
      checkBit("we3", register_we3, e.we);
      if (e.we) begin
         checkWord("a3", 32'(register_a3), 32'(e.a3));
         checkWord("wd3", register_wd3, e.wd);
      end
      checkBit("dmem_bus_ok", !bus_bad, 1'b1);
      checkBit("no_early_we3", !early_we, 1'b1);
      @(negedge clk);
      checkWord("next_pc", imem_addr, e.next_pc);
   endtask

   initial begin
      vec_t        vecs [16];
      exp_t        e;
      logic [31:0] instr;
      int          w;
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs [16];
      exp_t        e;
      logic [31:0] instr;
      int          w;
      reset = 1'b1; reset2 = 1'b1;
      imem_rdata = 32'd0; imem_rdata2 = 32'd0; dmem_ready = 1'b0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      for (int i = 0; i < 64; i++) mmem[i] = 32'd0;
      mpc = 32'h40;

      vecs[0]  = mk(32'h20010005, 0, 4, 1'b0, 1'b1, 5'd1, 32'd5,  1'b0, 1'b0, 32'd0, 32'd0,  32'h41);
      vecs[1]  = mk(32'h20020007, 0, 4, 1'b0, 1'b1, 5'd2, 32'd7,  1'b0, 1'b0, 32'd0, 32'd0,  32'h42);
      vecs[2]  = mk(32'h00221820, 0, 4, 1'b0, 1'b1, 5'd3, 32'd12, 1'b0, 1'b0, 32'd0, 32'd0,  32'h43);
      vecs[3]  = mk(32'hAC030008, 3, 7, 1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b1, 32'd8, 32'd12, 32'h44);
      vecs[4]  = mk(32'h8C040008, 0, 5, 1'b0, 1'b1, 5'd4, 32'd12, 1'b1, 1'b0, 32'd8, 32'd0,  32'h45);
      vecs[5]  = mk(32'h08000010, 0, 2, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0, 32'd0,  32'h10);
      vecs[6]  = mk(32'h1022FFFE, 0, 3, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0, 32'd0,  32'h11);
      vecs[7]  = mk(32'h08000010, 0, 2, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0, 32'd0,  32'h10);
      vecs[8]  = mk(32'h1021FFFE, 0, 3, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0, 32'd0,  32'h0F);
      vecs[9]  = mk(32'h00000000, 0, 2, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0, 32'd0,  32'h10);
      vecs[10] = mk(32'h00222822, 0, 4, 1'b0, 1'b1, 5'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 32'd0, 32'd0, 32'h11);
      vecs[11] = mk(32'h00A1302A, 0, 4, 1'b0, 1'b1, 5'd6, 32'd1,  1'b0, 1'b0, 32'd0, 32'd0,  32'h12);
      vecs[12] = mk(32'h00223824, 0, 4, 1'b0, 1'b1, 5'd7, 32'd5,  1'b0, 1'b0, 32'd0, 32'd0,  32'h13);
      vecs[13] = mk(32'h00224025, 0, 4, 1'b0, 1'b1, 5'd8, 32'd7,  1'b0, 1'b0, 32'd0, 32'd0,  32'h14);
      vecs[14] = mk(32'h00221801, 0, 2, 1'b1, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 32'd0, 32'd0,  32'h15);
      vecs[15] = mk(32'h8C090008, 2, 7, 1'b0, 1'b1, 5'd9, 32'd12, 1'b1, 1'b0, 32'd8, 32'd0,  32'h16);

      repeat (2) @(negedge clk);
      #1;
      checkWord("reset_pc", imem_addr, 32'h40);
      checkBit("reset_we3", register_we3, 1'b0);
      checkBit("reset_req", dmem_req, 1'b0);
      checkBit("reset_retire", retire, 1'b0);
      checkBit("reset_illegal", illegal, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         modelStep(vecs[i].instr, vecs[i].waits, e);
         applyStimulus(vecs[i].instr, vecs[i].waits, vecs[i].e);
      end

      // Reset while a load is stalled in MEM must abandon it immediately.
      imem_rdata = 32'h8C040008;
      dmem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkBit("stall_req", dmem_req, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      checkBit("midmem_rst_req", dmem_req, 1'b0);
      checkWord("midmem_rst_pc", imem_addr, 32'h40);
      checkBit("midmem_rst_retire", retire, 1'b0);
      checkBit("midmem_rst_we3", register_we3, 1'b0);
      reset = 1'b0;
      mpc = 32'h40;

      for (int i = 0; i < 150; i++) begin
         instr = randInstr();
         w = int'($urandom_range(0, 3));
         modelStep(instr, w, e);
         applyStimulus(instr, w, e);
      end
      reset = 1'b1;

      @(negedge clk);
      reset2 = 1'b0;
      imem_rdata2 = 32'h08000100;
      #1;
      checkWord("step4_reset_pc", imem_addr2, 32'h0);
      checkBit("step4_reset_req", dmem_req2, 1'b0);
      @(negedge clk);
      #1;
      checkBit("step4_j_retire", retire2, 1'b1);
      checkBit("step4_j_we3", register_we3_2, 1'b0);
      @(negedge clk);
      checkWord("step4_j_pc", imem_addr2, 32'h400);
      imem_rdata2 = 32'hFC000000;
      @(negedge clk);
      #1;
      checkBit("step4_illegal", illegal2, 1'b1);
      checkBit("step4_illegal_retire", retire2, 1'b0);
      @(negedge clk);
      checkWord("step4_illegal_pc", imem_addr2, 32'h404);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
